screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Central screen/game controller for the breakout design.
- Owns the screen state machine: start menu, level select, levels 1-8 and game over.
- Drives the game engine's run/level/restart controls.
- Picks which video source (menu, level screen, game-over screen, game) reaches the VGA pins, changing source only at a frame boundary so the monitor never sees a broken sync pulse.

Parameters:
- GRACE_CYCLES, 1000000: clk cycles after entering a level during which win/lose are ignored (10 ms at 100 MHz).
- GO_HOLD_FRAMES, 60: displayed frames that game over must show before confirm is accepted.
- NUM_LEVELS, 8: highest playable level.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- level_in  in  4  keyboard level code; 1..8 valid, 0 = none
- other_in  in  1  keyboard confirm key, level-sensitive
- win  in  1  game engine level-cleared flag
- lose  in  1  game engine endgame flag
- src_rgb  in  48  {game, game_over, level_screen, menu} 12-bit RGB each, menu in bits [11:0]
- src_hs  in  4  HS per source, same order
- src_vs  in  4  VS per source, same order
- state  out  4  current screen state
- game_run  out  1  high while state is a level
- game_level  out  3  active level minus 1
- game_restart  out  1  one-cycle pulse on entry to any level
- VGA_R  out  4  registered red
- VGA_G  out  4  registered green
- VGA_B  out  4  registered blue
- VGA_HS  out  1  registered horizontal sync
- VGA_VS  out  1  registered vertical sync

Behaviour:
- Reset (async, active-high): state=SM, display_sel=menu, grace and frame counters 0, game_run=0, game_level=0, game_restart=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1.
- confirm_edge is a rising edge of other_in, from a registered copy. The registered copy resets to 1, so a key held through reset does not count as an edge.
- SM: confirm_edge -> LS. On the entry cycle, latch baseline = level_in.
- LS: accept level_in only when it is 1..NUM_LEVELS and differs from baseline -> state L(level_in). Stale codes and 0/9..15 are ignored. confirm_edge in LS is ignored.
- Ln:
  - On entry: pulse game_restart for 1 cycle, set game_level=n-1, load the grace counter with GRACE_CYCLES.
  - Grace counter decrements to 0; win/lose are ignored while it is nonzero.
  - After grace, lose -> GO. Win with n<NUM_LEVELS -> L(n+1), which re-runs the entry actions. Win with n=NUM_LEVELS -> SM.
  - win and lose in the same cycle: lose takes priority.
- GO:
  - On entry, clear the frame counter.
  - The counter increments on each falling edge of the displayed VS and saturates at GO_HOLD_FRAMES.
  - confirm_edge while the counter equals GO_HOLD_FRAMES -> SM. Earlier confirm edges are discarded and are not queued.
- Encodings: SM=1111, LS=0001, GO=0010, L1..L8=0011..1010. Any other value goes to SM on the next clk.
- game_run = state in L1..L8, registered alongside state.
- Source selection:
  - target source from state: SM->menu, LS->level_screen, GO->game_over, Ln->game.
  - display_sel loads target only in the cycle after a 1->0 edge of the VS of the source currently displayed.
  - Several state changes within one frame collapse to the last target.
  - If display_sel already equals target, nothing happens.
- Output: VGA_* = registered mux of src_*[display_sel]. Latency is 1 clk from src inputs to pins.
- All state changes are synchronous to clk except reset. Asserting rst mid-frame or mid-level returns to reset values immediately.

Decomposition:
- Shared package screen_pkg: state encodings SM, LS, GO, L1..L8, a 2-bit source index enum (SRC_MENU=0, SRC_LS=1, SRC_GO=2, SRC_GAME=3), and the function state_to_src.
- One sub-module, frame_switch_mux: display_sel register, VS edge detect and the registered output mux.
- The FSM and counters stay in screen_sequencer.

Test Plan:
1. Reset, then pulse other_in with level_in=0, then set level_in=3 (GRACE_CYCLES=16) -> state 1111->0001->0101. game_restart is high for exactly 1 clk, game_level=2, game_run=1. VGA output switches to the game source only after the next falling edge of the menu/level VS, never mid-frame.
2. Hold level_in=5 through entry to LS -> stays in LS. Change level_in to 2 -> L2 (0100). Set level_in=9 in LS -> no transition.
3. In L8 with grace expired, assert win -> SM (1111). In L4, assert win -> L5 with a fresh game_restart pulse. Assert win and lose together in L2 -> GO (0010).
4. Assert lose 5 clk after level entry (GRACE_CYCLES=16) -> ignored. Assert lose again after 16 clk -> GO.
5. In GO with GO_HOLD_FRAMES=3, confirm edge after 2 VS falls -> stays in GO. Confirm after the 3rd VS fall -> SM, and display returns to menu at the following frame boundary.
6. Assert rst mid-frame while in L6 -> state=1111, outputs blank (RGB=0, HS=VS=1) asynchronously. Holding other_in high through rst release produces no transition.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the breakout screen sequencer: screen state
// encodings, video source indices and the state-to-source mapping.
package screen_pkg;

  // Screen state encodings (4-bit, legacy-compatible values).
  localparam logic [3:0] SM = 4'b1111;  // start menu
  localparam logic [3:0] LS = 4'b0001;  // level select
  localparam logic [3:0] GO = 4'b0010;  // game over
  localparam logic [3:0] L1 = 4'b0011;
  localparam logic [3:0] L2 = 4'b0100;
  localparam logic [3:0] L3 = 4'b0101;
  localparam logic [3:0] L4 = 4'b0110;
  localparam logic [3:0] L5 = 4'b0111;
  localparam logic [3:0] L6 = 4'b1000;
  localparam logic [3:0] L7 = 4'b1001;
  localparam logic [3:0] L8 = 4'b1010;

  // Video source index; matches the packing order of src_rgb/src_hs/src_vs.
  typedef enum logic [1:0] {
    SRC_MENU = 2'd0,
    SRC_LS   = 2'd1,
    SRC_GO   = 2'd2,
    SRC_GAME = 2'd3
  } src_t;

  // True when the encoding is one of the playable levels.
  function automatic logic is_level(input logic [3:0] s);
    case (s)
      L1, L2, L3, L4, L5, L6, L7, L8: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Which video source belongs to a screen state. Illegal encodings show
  // the menu, since they fall back to SM on the next clock anyway.
  function automatic src_t state_to_src(input logic [3:0] s);
    if (is_level(s)) return SRC_GAME;
    case (s)
      LS:      return SRC_LS;
      GO:      return SRC_GO;
      default: return SRC_MENU;
    endcase
  endfunction

endpackage

// File: rtl/frame_switch_mux.sv
// Frame-aligned video source switch: holds the displayed source, detects
// the falling edge of its VS and only then adopts a new target, so the
// monitor never sees a truncated frame. The selected source is registered
// onto the VGA pins with one clock of latency.
module frame_switch_mux
  import screen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  src_t        target,
  input  logic [47:0] src_rgb,
  input  logic [3:0]  src_hs,
  input  logic [3:0]  src_vs,
  output logic        vs_fall,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  src_t        display_sel;
  logic        vs_prev;
  logic        vs_cur;
  logic        hs_cur;
  logic [11:0] rgb_cur;

  // Pick the currently displayed source's signals.
  always_comb begin
    vs_cur  = src_vs[display_sel];
    hs_cur  = src_hs[display_sel];
    rgb_cur = src_rgb[12*display_sel +: 12];
  end

  assign vs_fall = vs_prev & ~vs_cur;

  // Track displayed VS and switch source right after its falling edge.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_sel <= SRC_MENU;
      vs_prev     <= 1'b1;
    end else begin
      vs_prev <= vs_cur;
      if (vs_fall) display_sel <= target;
    end
  end

  // Register the selected source onto the pins; idle sync level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VGA_R  <= 4'h0;
      VGA_G  <= 4'h0;
      VGA_B  <= 4'h0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_R  <= rgb_cur[11:8];
      VGA_G  <= rgb_cur[7:4];
      VGA_B  <= rgb_cur[3:0];
      VGA_HS <= hs_cur;
      VGA_VS <= vs_cur;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Central screen/game controller: menu, level select, levels and game
// over, plus the game engine run/level/restart controls. Video source
// selection is delegated to frame_switch_mux.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES   = 1000000,
  parameter int unsigned GO_HOLD_FRAMES = 60,
  parameter int unsigned NUM_LEVELS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  level_in,
  input  logic        other_in,
  input  logic        win,
  input  logic        lose,
  input  logic [47:0] src_rgb,
  input  logic [3:0]  src_hs,
  input  logic [3:0]  src_vs,
  output logic [3:0]  state,
  output logic        game_run,
  output logic [2:0]  game_level,
  output logic        game_restart,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int GRACE_W = (GRACE_CYCLES < 1)   ? 1 : $clog2(GRACE_CYCLES + 1);
  localparam int FRAME_W = (GO_HOLD_FRAMES < 1) ? 1 : $clog2(GO_HOLD_FRAMES + 1);

  logic [3:0]         state_next;
  logic [3:0]         baseline;
  logic [3:0]         lvl_idx;
  logic [GRACE_W-1:0] grace_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               confirm_prev;
  logic               confirm_edge;
  logic               level_ok;
  logic               entering_level;
  logic               vs_fall;
  src_t               target;

  assign confirm_edge   = other_in & ~confirm_prev;
  assign lvl_idx        = state - L1;
  assign level_ok       = (level_in != 4'd0) && (level_in <= 4'(NUM_LEVELS))
                          && (level_in != baseline);
  assign entering_level = is_level(state_next) && (state_next != state);
  assign target         = state_to_src(state);

  // Next screen state from keyboard and game engine events.
  // NOTE: state_next gets a default before the case so every path assigns
  // it; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      SM: if (confirm_edge) state_next = LS;
      LS: if (level_ok) state_next = level_in + 4'd2;
      GO: if (confirm_edge && frame_cnt == FRAME_W'(GO_HOLD_FRAMES)) state_next = SM;
      default: begin
        if (!is_level(state)) begin
          state_next = SM;
        end else if (grace_cnt == '0) begin
          if (lose)      state_next = GO;
          else if (win)  state_next = (lvl_idx < 4'(NUM_LEVELS - 1)) ? state + 4'd1 : SM;
        end
      end
    endcase
  end

  // Screen state, engine controls and level-select baseline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SM;
      game_run     <= 1'b0;
      game_level   <= 3'd0;
      game_restart <= 1'b0;
      baseline     <= 4'd0;
      confirm_prev <= 1'b1;  // a key held through reset is not an edge
    end else begin
      state        <= state_next;
      game_run     <= is_level(state_next);
      game_restart <= entering_level;
      confirm_prev <= other_in;
      if (entering_level) game_level <= 3'(state_next - L1);
      if (state == SM && state_next == LS) baseline <= level_in;
    end
  end

  // Grace window after level entry: win/lose are ignored until it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    grace_cnt <= '0;
    else if (entering_level)    grace_cnt <= GRACE_W'(GRACE_CYCLES);
    else if (grace_cnt != '0)   grace_cnt <= grace_cnt - 1'b1;
  end

  // Game-over hold: count displayed frames, saturating at the hold time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (state_next == GO && state != GO) begin
      frame_cnt <= '0;
    end else if (state == GO && vs_fall && frame_cnt != FRAME_W'(GO_HOLD_FRAMES)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  frame_switch_mux u_mux (
    .clk     (clk),
    .rst     (rst),
    .target  (target),
    .src_rgb (src_rgb),
    .src_hs  (src_hs),
    .src_vs  (src_vs),
    .vs_fall (vs_fall),
    .VGA_R   (VGA_R),
    .VGA_G   (VGA_G),
    .VGA_B   (VGA_B),
    .VGA_HS  (VGA_HS),
    .VGA_VS  (VGA_VS)
  );

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer with a short grace
// window (16 clocks) and a short game-over hold (3 frames).
module tb_screen_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  level_in;
  logic        other_in;
  logic        win;
  logic        lose;
  logic [47:0] src_rgb;
  logic [3:0]  src_hs;
  logic [3:0]  src_vs;
  logic [3:0]  state;
  logic        game_run;
  logic [2:0]  game_level;
  logic        game_restart;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] C_MENU = 12'hA01;
  localparam logic [11:0] C_LS   = 12'hB02;
  localparam logic [11:0] C_GO   = 12'hC03;
  localparam logic [11:0] C_GAME = 12'hD04;

  screen_sequencer #(
    .GRACE_CYCLES   (16),
    .GO_HOLD_FRAMES (3),
    .NUM_LEVELS     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .level_in     (level_in),
    .other_in     (other_in),
    .win          (win),
    .lose         (lose),
    .src_rgb      (src_rgb),
    .src_hs       (src_hs),
    .src_vs       (src_vs),
    .state        (state),
    .game_run     (game_run),
    .game_level   (game_level),
    .game_restart (game_restart),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and land 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One VS low/high cycle on all sources (they share frame timing).
  task automatic vs_frame();
    src_vs = 4'h0;
    tick(1);
    src_vs = 4'hF;
    tick(1);
  endtask

  task automatic confirm_pulse();
    other_in = 1'b1;
    tick(1);
    other_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    level_in = 4'd0;
    other_in = 1'b0;
    win      = 1'b0;
    lose     = 1'b0;
    src_rgb  = {C_GAME, C_GO, C_LS, C_MENU};
    src_hs   = 4'hF;
    src_vs   = 4'hF;

    // Reset state
    tick(2);
    check("rst_state", 16'(state), 16'hF);
    check("rst_run", 16'(game_run), 16'h0);
    check("rst_level", 16'(game_level), 16'h0);
    check("rst_restart", 16'(game_restart), 16'h0);
    check("rst_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'h000);
    check("rst_sync", 16'({VGA_HS, VGA_VS}), 16'h3);
    rst = 1'b0;
    tick(1);
    check("menu_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_MENU));

    // 1: SM -> LS -> L3, restart pulse, frame-aligned switch to game
    confirm_pulse();
    check("t1_ls", 16'(state), 16'h1);
    level_in = 4'd3;
    tick(1);
    check("t1_l3", 16'(state), 16'h5);
    check("t1_restart_hi", 16'(game_restart), 16'h1);
    check("t1_level", 16'(game_level), 16'h2);
    check("t1_run", 16'(game_run), 16'h1);
    tick(1);
    check("t1_restart_lo", 16'(game_restart), 16'h0);
    check("t1_no_midframe", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_MENU));
    src_vs = 4'h0;
    tick(1);
    check("t1_fall_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_MENU));
    check("t1_fall_vs", 16'(VGA_VS), 16'h0);
    src_vs = 4'hF;
    tick(1);
    check("t1_game_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_GAME));
    check("t1_game_vs", 16'(VGA_VS), 16'h1);

    // 4: lose during grace ignored, including its final cycle
    lose = 1'b1;
    tick(1);
    check("t4_early_lose", 16'(state), 16'h5);
    lose = 1'b0;
    tick(11);
    lose = 1'b1;
    tick(1);
    check("t4_last_grace", 16'(state), 16'h5);
    tick(1);
    check("t4_go", 16'(state), 16'h2);
    check("t4_go_run", 16'(game_run), 16'h0);
    lose = 1'b0;

    // 5: game over hold of 3 frames, early confirm discarded
    vs_frame();
    check("t5_go_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_GO));
    vs_frame();
    confirm_pulse();
    check("t5_early_confirm", 16'(state), 16'h2);
    tick(1);
    vs_frame();
    check("t5_not_queued", 16'(state), 16'h2);
    confirm_pulse();
    check("t5_to_sm", 16'(state), 16'hF);
    tick(1);
    check("t5_still_go_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_GO));
    vs_frame();
    check("t5_menu_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(C_MENU));

    // 2: stale code, out-of-range code and confirm ignored in LS
    level_in = 4'd5;
    confirm_pulse();
    check("t2_ls", 16'(state), 16'h1);
    tick(2);
    check("t2_stale", 16'(state), 16'h1);
    level_in = 4'd9;
    tick(2);
    check("t2_code9", 16'(state), 16'h1);
    confirm_pulse();
    check("t2_confirm_ls", 16'(state), 16'h1);
    tick(1);
    level_in = 4'd2;
    tick(1);
    check("t2_l2", 16'(state), 16'h4);
    check("t2_level", 16'(game_level), 16'h1);
    check("t2_restart", 16'(game_restart), 16'h1);

    // 3: win+lose together -> GO (lose wins)
    tick(16);
    win  = 1'b1;
    lose = 1'b1;
    tick(1);
    check("t3_both", 16'(state), 16'h2);
    win  = 1'b0;
    lose = 1'b0;
    vs_frame();
    vs_frame();
    vs_frame();
    confirm_pulse();
    check("t3_back_sm", 16'(state), 16'hF);
    tick(1);

    // 3: L4 win -> L5 with new restart and fresh grace
    confirm_pulse();
    level_in = 4'd4;
    tick(1);
    check("t3_l4", 16'(state), 16'h6);
    tick(16);
    win = 1'b1;
    tick(1);
    check("t3_l5", 16'(state), 16'h7);
    check("t3_l5_restart", 16'(game_restart), 16'h1);
    check("t3_l5_level", 16'(game_level), 16'h4);
    tick(1);
    check("t3_l5_grace", 16'(state), 16'h7);
    check("t3_l5_restart_lo", 16'(game_restart), 16'h0);
    win = 1'b0;
    tick(15);
    win = 1'b1;
    tick(1);
    check("t3_l6", 16'(state), 16'h8);
    win = 1'b0;
    tick(16);
    win = 1'b1;
    tick(1);
    check("t3_l7", 16'(state), 16'h9);
    win = 1'b0;
    tick(16);
    win = 1'b1;
    tick(1);
    check("t3_l8", 16'(state), 16'hA);
    check("t3_l8_level", 16'(game_level), 16'h7);
    win = 1'b0;
    tick(16);
    win = 1'b1;
    tick(1);
    check("t3_l8_win_sm", 16'(state), 16'hF);
    check("t3_l8_run", 16'(game_run), 16'h0);
    win = 1'b0;

    // 6: asynchronous reset mid-frame in L6, key held through release
    confirm_pulse();
    level_in = 4'd6;
    tick(1);
    check("t6_l6", 16'(state), 16'h8);
    tick(3);
    src_vs   = 4'h0;
    tick(1);
    other_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t6_async_state", 16'(state), 16'hF);
    check("t6_async_run", 16'(game_run), 16'h0);
    check("t6_async_level", 16'(game_level), 16'h0);
    check("t6_async_rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'h000);
    check("t6_async_sync", 16'({VGA_HS, VGA_VS}), 16'h3);
    tick(2);
    src_vs = 4'hF;
    rst    = 1'b0;
    tick(3);
    check("t6_held_key", 16'(state), 16'hF);
    other_in = 1'b0;
    tick(1);
    confirm_pulse();
    check("t6_fresh_edge", 16'(state), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
